// File: rtl/vram_port_arbiter_if.sv
// vram_port_arbiter_if: requester-side and VRAM-side signals of the VRAM port arbiter.
interface vram_port_arbiter_if #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 1
);
  logic                  disp_req_i;
  logic [ADDR_WIDTH-1:0] disp_addr_i;
  logic [DATA_WIDTH-1:0] disp_rd_data_o;
  logic                  disp_valid_o;
  logic                  sim_req_i;
  logic                  sim_we_i;
  logic [ADDR_WIDTH-1:0] sim_addr_i;
  logic [DATA_WIDTH-1:0] sim_wr_data_i;
  logic                  sim_gnt_o;
  logic [DATA_WIDTH-1:0] sim_rd_data_o;
  logic                  sim_valid_o;
  logic                  draw_req_i;
  logic [ADDR_WIDTH-1:0] draw_addr_i;
  logic [DATA_WIDTH-1:0] draw_wr_data_i;
  logic                  draw_gnt_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wr_data_o;
  logic                  mem_we_o;
  logic [DATA_WIDTH-1:0] mem_rd_data_i;
  modport master (
    output disp_req_i, disp_addr_i, sim_req_i, sim_we_i, sim_addr_i, sim_wr_data_i,
           draw_req_i, draw_addr_i, draw_wr_data_i, mem_rd_data_i,
    input  disp_rd_data_o, disp_valid_o, sim_gnt_o, sim_rd_data_o, sim_valid_o,
           draw_gnt_o, mem_addr_o, mem_wr_data_o, mem_we_o
  );
  modport slave (
    input  disp_req_i, disp_addr_i, sim_req_i, sim_we_i, sim_addr_i, sim_wr_data_i,
           draw_req_i, draw_addr_i, draw_wr_data_i, mem_rd_data_i,
    output disp_rd_data_o, disp_valid_o, sim_gnt_o, sim_rd_data_o, sim_valid_o,
           draw_gnt_o, mem_addr_o, mem_wr_data_o, mem_we_o
  );
endinterface

// File: rtl/vram_port_arbiter.sv
// vram_port_arbiter: shares one single-port VRAM between display (priority), sim and draw.
module vram_port_arbiter #(
  parameter int ACTIVE_COLUMNS = 640,
  parameter int ACTIVE_ROWS    = 480,
  parameter int ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS*ACTIVE_ROWS),
  parameter int DATA_WIDTH     = 1,
  parameter int MAX_WAIT       = 15
) (
  input logic clk_i,
  input logic reset_i,
  vram_port_arbiter_if.slave bus
);
  localparam int WW = $clog2(MAX_WAIT+1);
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(ACTIVE_COLUMNS*ACTIVE_ROWS);
  typedef enum logic [1:0] {OWN_NONE, OWN_DISP, OWN_SIM} owner_e;
  owner_e owner_q, owner_d;
  logic oor_q, oor_d, last_sim_q, last_sim_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [DATA_WIDTH-1:0] disp_data_q, disp_data_d, sim_data_q, sim_data_d, rd_data;
  logic disp_gnt, sim_gnt, draw_gnt, draw_first, disp_valid, sim_valid, oor;
  logic [ADDR_WIDTH-1:0] addr;
  always_comb begin
    draw_first = last_sim_q || wait_q == WW'(MAX_WAIT);
    disp_gnt = !reset_i && bus.disp_req_i;
    draw_gnt = !reset_i && !bus.disp_req_i && bus.draw_req_i && (draw_first || !bus.sim_req_i);
    sim_gnt = !reset_i && !bus.disp_req_i && bus.sim_req_i && !draw_gnt;
    addr = disp_gnt ? bus.disp_addr_i : sim_gnt ? bus.sim_addr_i : draw_gnt ? bus.draw_addr_i : '0;
    oor = {1'b0, addr} >= LIMIT;
    bus.mem_addr_o = addr;
    bus.mem_we_o = !oor && (draw_gnt || (sim_gnt && bus.sim_we_i));
    bus.mem_wr_data_o = sim_gnt ? bus.sim_wr_data_i : draw_gnt ? bus.draw_wr_data_i : '0;
    bus.sim_gnt_o = sim_gnt;
    bus.draw_gnt_o = draw_gnt;
    owner_d = disp_gnt ? OWN_DISP : (sim_gnt && !bus.sim_we_i) ? OWN_SIM : OWN_NONE;
    oor_d = oor;
    last_sim_d = sim_gnt ? 1'b1 : draw_gnt ? 1'b0 : last_sim_q;
    wait_d = (bus.draw_req_i && !draw_gnt) ? (wait_q == WW'(MAX_WAIT) ? wait_q : wait_q + 1'b1) : '0;
    // Read data lands one cycle after the grant; out-of-range reads return zero.
    rd_data = oor_q ? '0 : bus.mem_rd_data_i;
    disp_valid = owner_q == OWN_DISP;
    sim_valid = owner_q == OWN_SIM;
    disp_data_d = disp_valid ? rd_data : disp_data_q;
    sim_data_d = sim_valid ? rd_data : sim_data_q;
    bus.disp_valid_o = disp_valid;
    bus.sim_valid_o = sim_valid;
    bus.disp_rd_data_o = disp_data_d;
    bus.sim_rd_data_o = sim_data_d;
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      owner_q <= OWN_NONE;
      oor_q <= 1'b0;
      last_sim_q <= 1'b0;
      wait_q <= '0;
      disp_data_q <= '0;
      sim_data_q <= '0;
    end else begin
      owner_q <= owner_d;
      oor_q <= oor_d;
      last_sim_q <= last_sim_d;
      wait_q <= wait_d;
      disp_data_q <= disp_data_d;
      sim_data_q <= sim_data_d;
    end
  end
endmodule

// File: tb/tb_vram_port_arbiter.sv
// tb_vram_port_arbiter: directed scoreboard bench for vram_port_arbiter with a behavioural VRAM.
module tb_vram_port_arbiter;
  localparam int AW = 19;
  localparam int DW = 4;
  localparam int TOTAL = 640*480;
  typedef struct {bit disp; logic [DW-1:0] data;} rd_t;
  logic clk_i = 1'b0;
  logic reset_i = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  rd_t q[$];
  logic [DW-1:0] exp_disp = '0;
  logic [DW-1:0] exp_sim = '0;
  logic [DW-1:0] vram [int];

  vram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  vram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (.clk_i(clk_i), .reset_i(reset_i), .bus(bus));

  always #5 clk_i = ~clk_i;

  // Unwritten VRAM cells read as 4'hA so forced-zero reads are distinguishable.
  always @(posedge clk_i) begin
    bus.mem_rd_data_i <= vram.exists(int'(bus.mem_addr_o)) ? vram[int'(bus.mem_addr_o)] : 4'hA;
    if (bus.mem_we_o) vram[int'(bus.mem_addr_o)] = bus.mem_wr_data_o;
  end

  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
    return (int'(a) >= TOTAL) ? '0 : vram.exists(int'(a)) ? vram[int'(a)] : 4'hA;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, ".sim_gnt"}, 32'(bus.sim_gnt_o), 0);
    chk({tag, ".draw_gnt"}, 32'(bus.draw_gnt_o), 0);
    chk({tag, ".disp_valid"}, 32'(bus.disp_valid_o), 0);
    chk({tag, ".sim_valid"}, 32'(bus.sim_valid_o), 0);
    chk({tag, ".disp_data"}, 32'(bus.disp_rd_data_o), 0);
    chk({tag, ".sim_data"}, 32'(bus.sim_rd_data_o), 0);
    chk({tag, ".mem_addr"}, 32'(bus.mem_addr_o), 0);
    chk({tag, ".mem_we"}, 32'(bus.mem_we_o), 0);
    chk({tag, ".mem_wr_data"}, 32'(bus.mem_wr_data_o), 0);
  endtask

  task automatic disp(input bit req, input logic [AW-1:0] a);
    bus.disp_req_i = req;
    bus.disp_addr_i = a;
  endtask

  task automatic sim(input bit req, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.sim_req_i = req;
    bus.sim_we_i = we;
    bus.sim_addr_i = a;
    bus.sim_wr_data_i = d;
  endtask

  task automatic draw(input bit req, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.draw_req_i = req;
    bus.draw_addr_i = a;
    bus.draw_wr_data_i = d;
  endtask

  task automatic step(input string tag, input bit e_sim, input bit e_draw, input bit e_we,
                      input logic [AW-1:0] e_addr);
    rd_t r;
    bit have;
    @(negedge clk_i);
    have = q.size() > 0;
    r = '{disp: 1'b0, data: '0};
    if (have) r = q.pop_front();
    if (have && r.disp) exp_disp = r.data;
    if (have && !r.disp) exp_sim = r.data;
    chk({tag, ".disp_valid"}, 32'(bus.disp_valid_o), 32'(have && r.disp));
    chk({tag, ".sim_valid"}, 32'(bus.sim_valid_o), 32'(have && !r.disp));
    chk({tag, ".disp_data"}, 32'(bus.disp_rd_data_o), 32'(exp_disp));
    chk({tag, ".sim_data"}, 32'(bus.sim_rd_data_o), 32'(exp_sim));
    chk({tag, ".sim_gnt"}, 32'(bus.sim_gnt_o), 32'(e_sim));
    chk({tag, ".draw_gnt"}, 32'(bus.draw_gnt_o), 32'(e_draw));
    chk({tag, ".mem_we"}, 32'(bus.mem_we_o), 32'(e_we));
    chk({tag, ".mem_addr"}, 32'(bus.mem_addr_o), 32'(e_addr));
    if (bus.disp_req_i) q.push_back('{disp: 1'b1, data: data_of(bus.disp_addr_i)});
    else if (e_sim && !bus.sim_we_i) q.push_back('{disp: 1'b0, data: data_of(bus.sim_addr_i)});
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    disp(1, 100);
    sim(1, 1, 5, 4'hF);
    draw(1, 6, 4'hF);
    #3 zero_chk("rst");
    @(posedge clk_i);
    #1 zero_chk("rst_clk");
    disp(0, 0);
    sim(0, 0, 0, 0);
    draw(0, 0, 0);
    reset_i = 1'b0;
    sim(1, 1, 10, 4'h3);
    draw(1, 20, 4'h6);
    step("alt0", 1, 0, 1, 10);
    step("alt1", 0, 1, 1, 20);
    step("alt2", 1, 0, 1, 10);
    step("alt3", 0, 1, 1, 20);
    sim(0, 0, 0, 0);
    draw(0, 0, 0);
    step("idle0", 0, 0, 0, 0);
    disp(1, 100);
    sim(1, 0, 20, 0);
    step("disp_pri", 0, 0, 0, 100);
    disp(0, 0);
    step("sim_rd20", 1, 0, 0, 20);
    sim(0, 0, 0, 0);
    step("idle1", 0, 0, 0, 0);
    sim(1, 1, 5, 4'h9);
    step("sim_wr5", 1, 0, 1, 5);
    sim(1, 0, 5, 0);
    step("sim_rd5", 1, 0, 0, 5);
    sim(0, 0, 0, 0);
    step("idle2", 0, 0, 0, 0);
    step("idle3", 0, 0, 0, 0);
    draw(1, AW'(TOTAL), 4'hF);
    step("draw_oor", 0, 1, 0, AW'(TOTAL));
    draw(0, 0, 0);
    sim(1, 0, AW'(TOTAL), 0);
    step("sim_oor", 1, 0, 0, AW'(TOTAL));
    sim(0, 0, 0, 0);
    step("idle4", 0, 0, 0, 0);
    draw(1, 30, 4'h2);
    step("draw30", 0, 1, 1, 30);
    draw(1, 40, 4'h5);
    for (int i = 0; i < 15; i++) begin
      disp(1, AW'(20 + i));
      step("disp_busy", 0, 0, 0, AW'(20 + i));
    end
    disp(0, 0);
    sim(1, 0, 10, 0);
    step("draw_force", 0, 1, 1, 40);
    draw(0, 0, 0);
    step("sim_after", 1, 0, 0, 10);
    sim(0, 0, 0, 0);
    step("idle5", 0, 0, 0, 0);
    disp(1, 10);
    step("disp_pre_rst", 0, 0, 0, 10);
    reset_i = 1'b1;
    #1 zero_chk("rst_async");
    q.delete();
    exp_disp = '0;
    exp_sim = '0;
    disp(0, 0);
    @(posedge clk_i);
    #1 reset_i = 1'b0;
    step("post_rst", 0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vram_port_arbiter.md
VRAM_PORT_ARBITER -- requirements
Module: vram_port_arbiter

Interface
- REQ-001 Parameter ACTIVE_COLUMNS, default 640, pixels per row.
- REQ-002 Parameter ACTIVE_ROWS, default 480, rows per frame.
- REQ-003 Parameter ADDR_WIDTH, default $clog2(ACTIVE_COLUMNS*ACTIVE_ROWS), pixel address width.
- REQ-004 Parameter DATA_WIDTH, default 1, bits per pixel.
- REQ-005 Parameter MAX_WAIT, default 15, maximum cycles the draw port may be refused before it is forced ahead of the sim port.
- REQ-006 Port clk_i, input, 1, clock; all state updates on its rising edge.
- REQ-007 Port reset_i, input, 1, reset; asynchronous, active-high.
- REQ-008 Ports disp_req_i (input, 1) and disp_addr_i (input, ADDR_WIDTH): display read request and its address.
- REQ-009 Ports disp_rd_data_o (output, DATA_WIDTH) and disp_valid_o (output, 1): display read data and its valid strobe.
- REQ-010 Ports sim_req_i (input, 1), sim_we_i (input, 1), sim_addr_i (input, ADDR_WIDTH) and sim_wr_data_i (input, DATA_WIDTH): simulation read/write request.
- REQ-011 Ports sim_gnt_o (output, 1), sim_rd_data_o (output, DATA_WIDTH) and sim_valid_o (output, 1): simulation grant, read data and valid strobe.
- REQ-012 Ports draw_req_i (input, 1), draw_addr_i (input, ADDR_WIDTH) and draw_wr_data_i (input, DATA_WIDTH): user-draw write request.
- REQ-013 Port draw_gnt_o, output, 1: user-draw grant.
- REQ-014 Ports mem_addr_o (output, ADDR_WIDTH), mem_wr_data_o (output, DATA_WIDTH) and mem_we_o (output, 1): single-port VRAM command.
- REQ-015 Port mem_rd_data_i, input, DATA_WIDTH: VRAM read data, valid one cycle after the address is presented.

Function
- REQ-016 At most one requester is granted per cycle; grant and VRAM command are combinational from current requests and registered arbiter state.
- REQ-017 Display has absolute priority; a cycle with disp_req_i=1 always serves the display, as a read.
- REQ-018 When the display is idle, sim and draw alternate round-robin; a registered last-winner bit flips to the requester granted.
- REQ-019 A registered wait counter increments on each cycle draw_req_i=1 without draw_gnt_o and clears on a draw grant or when draw_req_i=0.
- REQ-020 When the wait counter reaches MAX_WAIT, draw wins over sim regardless of the last-winner bit; the counter saturates at MAX_WAIT.
- REQ-021 When granted, a requester drives mem_addr_o from its own address; mem_we_o=1 for draw, and sim_we_i for sim.
- REQ-022 When no requester is granted, mem_we_o=0, mem_addr_o=0 and mem_wr_data_o=0.
- REQ-023 For an address >= ACTIVE_COLUMNS*ACTIVE_ROWS, the request is still granted, mem_we_o is forced to 0, and any resulting read returns 0.
- REQ-024 Read latency is exactly 1 cycle: a registered owner tag (NONE/DISP/SIM) plus an out-of-range flag route mem_rd_data_i to the owner's data output with a one-cycle valid pulse.
- REQ-025 Data outputs hold their last value when not valid.
- REQ-026 Write grants (draw, or sim with sim_we_i=1) produce no valid pulse.
- REQ-027 Requesters hold request, address and data until granted; a request dropped before grant is discarded without side effects.

Reset
- REQ-028 While reset_i=1, the owner tag is NONE, the last-winner bit is DRAW (so sim wins first) and the wait counter is 0.
- REQ-029 While reset_i=1, all grant, valid, data and mem_* outputs are 0.
- REQ-030 Reset asserted mid-read suppresses that read's valid pulse.

Verification
- REQ-031 disp_req_i=1 and sim_req_i=1 in the same cycle, disp_addr_i=100 -> mem_addr_o=100, sim_gnt_o=0; next cycle disp_valid_o=1 with disp_rd_data_o equal to mem_rd_data_i.
- REQ-032 sim and draw both requesting continuously, display idle, immediately after reset -> grants alternate sim, draw, sim, draw.
- REQ-033 draw_req_i=1 with display busy for 15 cycles, then the display releases while sim also requests -> draw_gnt_o=1 on that first free cycle.
- REQ-034 draw write to address 307200 -> draw_gnt_o=1, mem_we_o=0; sim read of address 307200 -> sim_valid_o=1 with sim_rd_data_o=0.
- REQ-035 sim write to address 5 with data 1, then sim read of address 5 -> mem_we_o=1 on the write; sim_valid_o pulses only for the read, one cycle after its grant.
- REQ-036 reset_i asserted asynchronously the cycle after a display read grant -> all outputs 0 immediately and no disp_valid_o pulse.
